// File: rtl/truth_table_sweep_ctrl.sv
// Truth-table sweep sequencer: drives every input combination of an N_IN-input
// combinational block, samples its single output after a settle window, and
// compares against a runtime-loaded expected table under a care mask.
module truth_table_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expect_tt,
  input  logic [(1<<N_IN)-1:0]   care_tt,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          fail_count,
  output logic [N_IN-1:0]        first_fail_idx,
  output logic                   first_fail_valid,
  output logic [(1<<N_IN)-1:0]   observed_tt
);

  localparam int ROWS = 1 << N_IN;
  // A zero-length settle window still needs a one-bit counter that stays at 0.
  localparam int CW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE);
  localparam logic [N_IN-1:0] ROW_LAST    = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [ROWS-1:0]   expect_r, expect_s;
  logic [ROWS-1:0]   care_r, care_s;
  logic [N_IN-1:0]   dut_in_r, dut_in_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              pass_r, pass_s;
  logic [N_IN:0]     fail_count_r, fail_count_s;
  logic [N_IN-1:0]   ffi_r, ffi_s;
  logic              ffv_r, ffv_s;
  logic [ROWS-1:0]   obs_r, obs_s;
  logic              sample_s;
  logic              mismatch_s;

  assign dut_in           = dut_in_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign fail_count       = fail_count_r;
  assign first_fail_idx   = ffi_r;
  assign first_fail_valid = ffv_r;
  assign observed_tt      = obs_r;

  // Next-state and next-output logic: abort beats start beats sweep progress.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    expect_s     = expect_r;
    care_s       = care_r;
    dut_in_s     = dut_in_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    pass_s       = pass_r;
    fail_count_s = fail_count_r;
    ffi_s        = ffi_r;
    ffv_s        = ffv_r;
    obs_s        = obs_r;
    sample_s     = (state_r == ST_RUN) && (cnt_r == SETTLE_LAST);
    mismatch_s   = sample_s && care_r[dut_in_r] && (dut_out != expect_r[dut_in_r]);

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s      = ST_RUN;
          cnt_s        = '0;
          expect_s     = expect_tt;
          care_s       = care_tt;
          dut_in_s     = '0;
          busy_s       = 1'b1;
          pass_s       = 1'b0;
          fail_count_s = '0;
          ffi_s        = '0;
          ffv_s        = 1'b0;
          obs_s        = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Partial results stay visible; only the sequencing stops.
          state_s  = ST_IDLE;
          busy_s   = 1'b0;
          cnt_s    = '0;
          dut_in_s = '0;
        end else if (sample_s) begin
          obs_s[dut_in_r] = dut_out;
          cnt_s           = '0;
          if (mismatch_s) begin
            fail_count_s = fail_count_r + (N_IN+1)'(1);
          end else begin
            fail_count_s = fail_count_r;
          end
          if (mismatch_s && !ffv_r) begin
            ffi_s = dut_in_r;
            ffv_s = 1'b1;
          end else begin
            ffi_s = ffi_r;
          end
          if (dut_in_r == ROW_LAST) begin
            state_s  = ST_DONE;
            busy_s   = 1'b0;
            done_s   = 1'b1;
            pass_s   = (fail_count_s == '0);
            dut_in_s = '0;
          end else begin
            dut_in_s = dut_in_r + N_IN'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s  = ST_IDLE;
        busy_s   = 1'b0;
        cnt_s    = '0;
        dut_in_s = '0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset clears every result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      expect_r     <= '0;
      care_r       <= '0;
      dut_in_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_count_r <= '0;
      ffi_r        <= '0;
      ffv_r        <= 1'b0;
      obs_r        <= '0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      expect_r     <= expect_s;
      care_r       <= care_s;
      dut_in_r     <= dut_in_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      fail_count_r <= fail_count_s;
      ffi_r        <= ffi_s;
      ffv_r        <= ffv_s;
      obs_r        <= obs_s;
    end
  end

endmodule
